// File: rtl/gt_link_latency_monitor_if.sv
// GT lane bundle between the latency monitor and the transceiver wrapper.
// Lane n occupies data bits [16n+15:16n] and k bits [2n+1:2n].
interface gt_link_latency_monitor_if #(
  parameter int g_NUM_LANES = 2
);
  logic [16*g_NUM_LANES-1:0] tx_data_o;
  logic [2*g_NUM_LANES-1:0]  tx_k_o;
  logic [16*g_NUM_LANES-1:0] rx_data_i;
  logic [2*g_NUM_LANES-1:0]  rx_k_i;
  logic [g_NUM_LANES-1:0]    rx_aligned_i;
  logic [g_NUM_LANES-1:0]    rx_realign_o;

  // Monitor side: generates TX pattern, consumes RX stream.
  modport master (
    output tx_data_o, tx_k_o, rx_realign_o,
    input  rx_data_i, rx_k_i, rx_aligned_i
  );

  // Transceiver side.
  modport slave (
    input  tx_data_o, tx_k_o, rx_realign_o,
    output rx_data_i, rx_k_i, rx_aligned_i
  );
endinterface

// File: rtl/gt_link_latency_monitor.sv
// Sends timestamps with periodic IDLE commas on every GT lane and measures the
// per-lane loopback latency, tracking min/max latency, errors and a pass flag.
module gt_link_latency_monitor #(
  parameter int          g_NUM_LANES           = 2,
  parameter logic [15:0] g_IDLE                = 16'hBC95,
  parameter int          g_IDLE_PERIOD         = 193,
  parameter int          g_BLIND_PERIOD        = 10,
  parameter int          g_NUM_SUCCESSFUL_DATA = 1000
) (
  input  logic                       usrclk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic                       clear_stats_i,
  gt_link_latency_monitor_if.master  gt,
  output logic [g_NUM_LANES-1:0]     fail_o,
  output logic [16*g_NUM_LANES-1:0]  latency_min_o,
  output logic [16*g_NUM_LANES-1:0]  latency_max_o,
  output logic [16*g_NUM_LANES-1:0]  err_cnt_o
);

  localparam int IDLE_CW  = $clog2(g_IDLE_PERIOD);
  localparam int BLIND_CW = $clog2(g_BLIND_PERIOD + 1) + 1;
  localparam int SUCC_CW  = $clog2(g_NUM_SUCCESSFUL_DATA + 2) + 1;
  localparam logic [SUCC_CW-1:0] SUCC_MAX = SUCC_CW'(g_NUM_SUCCESSFUL_DATA + 1);

  typedef enum logic [1:0] {
    ST_UNALIGNED,
    ST_BLIND,
    ST_WAIT_COMMA,
    ST_LOCKED
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0]               r_ts;
  logic [IDLE_CW-1:0]        r_idle_cnt;
  logic [16*g_NUM_LANES-1:0] r_tx_data;
  logic [2*g_NUM_LANES-1:0]  r_tx_k;
  logic [g_NUM_LANES-1:0]    r_realign;
  logic                      w_force_idle;

  assign w_force_idle = !valid_i || (r_idle_cnt == '0);

  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      r_ts       <= '0;
      r_idle_cnt <= '0;
      r_tx_data  <= {g_NUM_LANES{g_IDLE}};
      r_tx_k     <= {g_NUM_LANES{2'b10}};
      r_realign  <= '0;
    end else begin
      r_ts       <= r_ts + 16'd1;
      r_idle_cnt <= (r_idle_cnt == IDLE_CW'(g_IDLE_PERIOD - 1)) ? '0 : r_idle_cnt + 1'b1;
      r_tx_data  <= w_force_idle ? {g_NUM_LANES{g_IDLE}} : {g_NUM_LANES{r_ts}};
      r_tx_k     <= w_force_idle ? {g_NUM_LANES{2'b10}} : '0;
      r_realign  <= {g_NUM_LANES{valid_i}} & ~gt.rx_aligned_i;
    end
  end

  assign gt.tx_data_o    = r_tx_data;
  assign gt.tx_k_o       = r_tx_k;
  assign gt.rx_realign_o = r_realign;

  for (genvar n = 0; n < g_NUM_LANES; n++) begin : g_lane
    state_t              r_state, w_state_nxt;
    logic [BLIND_CW-1:0] r_blind_cnt;
    logic [SUCC_CW-1:0]  r_succ_cnt;
    logic [15:0]         w_rx_data;
    logic [1:0]          w_rx_k;
    logic                w_aligned, w_rx_idle, w_sample, w_error;
    logic [15:0]         r_lat_p0;
    logic                r_vld_p0;
    logic                r_fail;
    logic [15:0]         r_min, r_max, r_err;

    assign w_rx_data = gt.rx_data_i[16*n +: 16];
    assign w_rx_k    = gt.rx_k_i[2*n +: 2];
    assign w_aligned = gt.rx_aligned_i[n];
    assign w_rx_idle = (w_rx_k == 2'b10) && (w_rx_data == g_IDLE);

    always_comb begin
      w_state_nxt = r_state;
      w_sample    = 1'b0;
      w_error     = 1'b0;
      if (!w_aligned) begin
        w_state_nxt = ST_UNALIGNED;
      end else begin
        case (r_state)
          ST_UNALIGNED: w_state_nxt = ST_BLIND;
          ST_BLIND: begin
            if (r_blind_cnt == BLIND_CW'(g_BLIND_PERIOD)) w_state_nxt = ST_WAIT_COMMA;
          end
          ST_WAIT_COMMA: begin
            if (w_rx_idle) w_state_nxt = ST_LOCKED;
            else if (w_rx_k != 2'b00) w_error = 1'b1;
          end
          ST_LOCKED: begin
            if (w_rx_k == 2'b00) begin
              w_sample = 1'b1;
            end else if (!w_rx_idle) begin
              w_error     = 1'b1;
              w_state_nxt = ST_WAIT_COMMA;
            end
          end
          default: w_state_nxt = ST_UNALIGNED;
        endcase
      end
    end

    always_ff @(posedge usrclk_i) begin
      if (rst_i) begin
        r_state     <= ST_UNALIGNED;
        r_blind_cnt <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_blind_cnt <= (r_state == ST_BLIND && w_state_nxt == ST_BLIND) ?
                       r_blind_cnt + 1'b1 : '0;
      end
    end

    // p0: latency captured modulo 2^16, so a timestamp wrap needs no special case
    always_ff @(posedge usrclk_i) begin
      r_lat_p0 <= r_ts - w_rx_data;
    end

    // p1: min/max fold; clear also kills the sample in flight
    always_ff @(posedge usrclk_i) begin
      if (rst_i || clear_stats_i) begin
        r_vld_p0   <= 1'b0;
        r_fail     <= 1'b1;
        r_min      <= 16'hFFFF;
        r_max      <= 16'h0000;
        r_err      <= 16'h0000;
        r_succ_cnt <= '0;
      end else begin
        r_vld_p0 <= w_sample;
        if (r_vld_p0) begin
          if (r_lat_p0 < r_min) r_min <= r_lat_p0;
          if (r_lat_p0 > r_max) r_max <= r_lat_p0;
        end
        if (!w_aligned || w_error) begin
          r_fail     <= 1'b1;
          r_succ_cnt <= '0;
          if (w_error) r_err <= sat_inc16(r_err);
        end else begin
          if (w_sample && r_succ_cnt != SUCC_MAX) r_succ_cnt <= r_succ_cnt + 1'b1;
          if (r_succ_cnt == SUCC_MAX) r_fail <= 1'b0;
        end
      end
    end

    assign fail_o[n]               = r_fail;
    assign latency_min_o[16*n +: 16] = r_min;
    assign latency_max_o[16*n +: 16] = r_max;
    assign err_cnt_o[16*n +: 16]     = r_err;
  end

endmodule

// File: tb/tb_gt_link_latency_monitor.sv
// Bench for gt_link_latency_monitor: per-lane loopback channel with selectable
// delay and word injection, checked against expected latency/error counts.
module tb_gt_link_latency_monitor;
  localparam int          NL     = 2;
  localparam logic [15:0] IDLE   = 16'hBC95;
  localparam int          IDLE_P = 193;
  localparam int          BLIND  = 10;
  localparam int          N_OK   = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, valid, clear;
  logic [NL-1:0]    aligned;
  logic [NL-1:0]    fail;
  logic [16*NL-1:0] lat_min, lat_max, err_cnt;

  int          dly      [NL];
  logic        inj_en   [NL];
  logic [15:0] inj_data [NL];
  logic [1:0]  inj_k    [NL];
  logic [15:0] dl_data  [NL][16];
  logic [1:0]  dl_k     [NL][16];
  logic [15:0] m_ts;
  int          rx_words [NL];
  int          checks = 0;
  int          errors = 0;

  gt_link_latency_monitor_if #(.g_NUM_LANES(NL)) gt_if ();

  gt_link_latency_monitor #(.g_NUM_LANES(NL)) dut (
    .usrclk_i      (clk),
    .rst_i         (rst),
    .valid_i       (valid),
    .clear_stats_i (clear),
    .gt            (gt_if),
    .fail_o        (fail),
    .latency_min_o (lat_min),
    .latency_max_o (lat_max),
    .err_cnt_o     (err_cnt)
  );

  // Channel: lane delay of d registers, so expected latency is d+1 (TX register + channel).
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      dl_data[l][0] <= gt_if.tx_data_o[16*l +: 16];
      dl_k[l][0]    <= gt_if.tx_k_o[2*l +: 2];
      for (int i = 1; i < 16; i++) begin
        dl_data[l][i] <= dl_data[l][i-1];
        dl_k[l][i]    <= dl_k[l][i-1];
      end
      if (!rst && gt_if.rx_k_i[2*l +: 2] == 2'b00) rx_words[l] <= rx_words[l] + 1;
    end
    m_ts <= rst ? 16'd0 : m_ts + 16'd1;
  end

  always_comb begin
    gt_if.rx_data_i = '0;
    gt_if.rx_k_i    = '0;
    for (int l = 0; l < NL; l++) begin
      if (inj_en[l]) begin
        gt_if.rx_data_i[16*l +: 16] = inj_data[l];
        gt_if.rx_k_i[2*l +: 2]      = inj_k[l];
      end else begin
        gt_if.rx_data_i[16*l +: 16] = dl_data[l][dly[l]-1];
        gt_if.rx_k_i[2*l +: 2]      = dl_k[l][dly[l]-1];
      end
    end
  end
  assign gt_if.rx_aligned_i = aligned;

  function automatic logic [15:0] sl(input logic [16*NL-1:0] v, input int l);
    return v[16*l +: 16];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(10);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid = 1'b1; aligned = '1; clear = 1'b1; rst = 1'b1;
    for (int l = 0; l < NL; l++) begin
      dly[l] = 5; inj_en[l] = 1'b0; inj_data[l] = '0; inj_k[l] = '0;
    end
    step(10);
    checks++; if (gt_if.tx_data_o !== {NL{IDLE}}) begin errors++; $display("FAIL rst_tx_data got %h want %h", gt_if.tx_data_o, {NL{IDLE}}); end
    checks++; if (gt_if.tx_k_o !== {NL{2'b10}}) begin errors++; $display("FAIL rst_tx_k got %b want %b", gt_if.tx_k_o, {NL{2'b10}}); end
    checks++; if (gt_if.rx_realign_o !== {NL{1'b0}}) begin errors++; $display("FAIL rst_realign got %b want 0", gt_if.rx_realign_o); end
    checks++; if (fail !== {NL{1'b1}}) begin errors++; $display("FAIL rst_fail got %b want all 1", fail); end
    checks++; if (lat_min !== {NL{16'hFFFF}}) begin errors++; $display("FAIL rst_min got %h want all FFFF", lat_min); end
    checks++; if (lat_max !== '0) begin errors++; $display("FAIL rst_max got %h want 0", lat_max); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL rst_err got %h want 0", err_cnt); end
    rst = 1'b0; clear = 1'b0;
    step(1);
    checks++; if (sl(gt_if.tx_data_o, 0) !== IDLE || gt_if.tx_k_o[1:0] !== 2'b10) begin errors++; $display("FAIL first_tx_idle got %h/%b want %h/10", sl(gt_if.tx_data_o, 0), gt_if.tx_k_o[1:0], IDLE); end
    step(1);
    checks++; if (sl(gt_if.tx_data_o, 0) !== 16'h0001 || gt_if.tx_k_o[1:0] !== 2'b00) begin errors++; $display("FAIL second_tx_ts got %h/%b want 0001/00", sl(gt_if.tx_data_o, 0), gt_if.tx_k_o[1:0]); end
    checks++; if (sl(gt_if.tx_data_o, 1) !== 16'h0001) begin errors++; $display("FAIL second_tx_ts_lane1 got %h want 0001", sl(gt_if.tx_data_o, 1)); end
  endtask

  task automatic test_valid_low();
    valid = 1'b0; aligned = 2'b10;
    step(3);
    checks++; if (gt_if.tx_k_o !== {NL{2'b10}}) begin errors++; $display("FAIL vlow_tx_k got %b want all 10", gt_if.tx_k_o); end
    checks++; if (gt_if.tx_data_o !== {NL{IDLE}}) begin errors++; $display("FAIL vlow_tx_data got %h want all %h", gt_if.tx_data_o, IDLE); end
    checks++; if (gt_if.rx_realign_o !== 2'b00) begin errors++; $display("FAIL vlow_realign got %b want 00", gt_if.rx_realign_o); end
    valid = 1'b1;
    step(1);
    checks++; if (gt_if.rx_realign_o !== 2'b01) begin errors++; $display("FAIL vhigh_realign got %b want 01", gt_if.rx_realign_o); end
    aligned = '1;
    step(1);
    checks++; if (gt_if.rx_realign_o !== 2'b00) begin errors++; $display("FAIL aligned_realign got %b want 00", gt_if.rx_realign_o); end
  endtask

  task automatic test_loopback_pass();
    int  base [NL];
    int  words [NL];
    bit  done [NL];
    for (int l = 0; l < NL; l++) dly[l] = 5;
    reset_pulse();
    for (int l = 0; l < NL; l++) begin base[l] = rx_words[l]; done[l] = 1'b0; words[l] = 0; end
    for (int c = 0; c < 3000 && !(done[0] && done[1]); c++) begin
      step(1);
      for (int l = 0; l < NL; l++) begin
        if (!done[l] && fail[l] == 1'b0) begin done[l] = 1'b1; words[l] = rx_words[l] - base[l]; end
      end
    end
    for (int l = 0; l < NL; l++) begin
      checks++; if (!done[l]) begin errors++; $display("FAIL pass_timeout lane%0d fail stayed %b want 0", l, fail[l]); end
      checks++; if (words[l] < N_OK + 1 || words[l] > N_OK + 1 + BLIND + 2 + IDLE_P + 2) begin errors++; $display("FAIL pass_words lane%0d got %0d want %0d..%0d", l, words[l], N_OK + 1, N_OK + 1 + BLIND + 2 + IDLE_P + 2); end
      checks++; if (sl(lat_min, l) !== 16'd6) begin errors++; $display("FAIL pass_min lane%0d got %0d want 6", l, sl(lat_min, l)); end
      checks++; if (sl(lat_max, l) !== 16'd6) begin errors++; $display("FAIL pass_max lane%0d got %0d want 6", l, sl(lat_max, l)); end
      checks++; if (sl(err_cnt, l) !== 16'd0) begin errors++; $display("FAIL pass_err lane%0d got %0d want 0", l, sl(err_cnt, l)); end
    end
  endtask

  task automatic test_lane_error();
    inj_data[1] = 16'h1234; inj_k[1] = 2'b01; inj_en[1] = 1'b1;
    step(1);
    inj_en[1] = 1'b0;
    checks++; if (sl(err_cnt, 1) !== 16'd1) begin errors++; $display("FAIL lerr_cnt1 got %0d want 1", sl(err_cnt, 1)); end
    checks++; if (fail[1] !== 1'b1) begin errors++; $display("FAIL lerr_fail1 got %b want 1", fail[1]); end
    checks++; if (fail[0] !== 1'b0) begin errors++; $display("FAIL lerr_fail0 got %b want 0", fail[0]); end
    checks++; if (sl(err_cnt, 0) !== 16'd0) begin errors++; $display("FAIL lerr_cnt0 got %0d want 0", sl(err_cnt, 0)); end
    checks++; if (sl(lat_min, 0) !== 16'd6 || sl(lat_max, 0) !== 16'd6) begin errors++; $display("FAIL lerr_minmax0 got %0d/%0d want 6/6", sl(lat_min, 0), sl(lat_max, 0)); end
  endtask

  task automatic test_realign();
    int base;
    int words;
    bit ok;
    aligned[0] = 1'b0;
    step(1);
    checks++; if (fail[0] !== 1'b1) begin errors++; $display("FAIL realign_fail got %b want 1", fail[0]); end
    aligned[0] = 1'b1; inj_en[0] = 1'b1; inj_k[0] = 2'b01; inj_data[0] = 16'h0000;
    step(12);
    checks++; if (sl(err_cnt, 0) !== 16'd0) begin errors++; $display("FAIL blind_ignored got %0d want 0", sl(err_cnt, 0)); end
    step(1);
    checks++; if (sl(err_cnt, 0) !== 16'd1) begin errors++; $display("FAIL blind_end got %0d want 1", sl(err_cnt, 0)); end
    inj_en[0] = 1'b0;
    base = rx_words[0]; ok = 1'b0; words = 0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      step(1);
      if (fail[0] == 1'b0) begin ok = 1'b1; words = rx_words[0] - base; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL repass_timeout fail0 %b want 0", fail[0]); end
    checks++; if (words < N_OK + 1 || words > N_OK + 1 + IDLE_P + 2) begin errors++; $display("FAIL repass_words got %0d want %0d..%0d", words, N_OK + 1, N_OK + 1 + IDLE_P + 2); end
    checks++; if (sl(err_cnt, 1) !== 16'd1) begin errors++; $display("FAIL realign_lane1_err got %0d want 1", sl(err_cnt, 1)); end
    checks++; if (sl(lat_min, 0) !== 16'd6) begin errors++; $display("FAIL realign_min0 got %0d want 6", sl(lat_min, 0)); end
  endtask

  task automatic test_clear();
    inj_data[1] = 16'hDEAD; inj_k[1] = 2'b01; inj_en[1] = 1'b1; clear = 1'b1;
    step(1);
    inj_en[1] = 1'b0; clear = 1'b0;
    checks++; if (sl(err_cnt, 1) !== 16'd0) begin errors++; $display("FAIL clr_err1 got %0d want 0", sl(err_cnt, 1)); end
    checks++; if (sl(lat_min, 1) !== 16'hFFFF || sl(lat_max, 1) !== 16'h0000) begin errors++; $display("FAIL clr_minmax1 got %h/%h want FFFF/0000", sl(lat_min, 1), sl(lat_max, 1)); end
    checks++; if (fail !== 2'b11) begin errors++; $display("FAIL clr_fail got %b want 11", fail); end
    checks++; if (sl(err_cnt, 0) !== 16'd0) begin errors++; $display("FAIL clr_err0 got %0d want 0", sl(err_cnt, 0)); end
    step(1);
    checks++; if (sl(lat_min, 0) !== 16'hFFFF) begin errors++; $display("FAIL clr_kills_sample got %h want FFFF", sl(lat_min, 0)); end
    step(2);
    checks++; if (sl(lat_min, 0) !== 16'd6 || sl(lat_max, 0) !== 16'd6) begin errors++; $display("FAIL clr_resample got %0d/%0d want 6/6", sl(lat_min, 0), sl(lat_max, 0)); end
  endtask

  task automatic test_random();
    int exp_err [NL];
    int ncyc;
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < NL; l++) begin dly[l] = $urandom_range(1, 8); exp_err[l] = 0; end
      reset_pulse();
      step(IDLE_P + BLIND + 20);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      ncyc = $urandom_range(150, 400);
      for (int c = 0; c < ncyc; c++) begin
        for (int l = 0; l < NL; l++) begin
          if ($urandom_range(0, 29) == 0) begin
            inj_en[l] = 1'b1; inj_k[l] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            inj_data[l] = 16'($urandom); exp_err[l]++;
          end else begin
            inj_en[l] = 1'b0;
          end
        end
        step(1);
      end
      for (int l = 0; l < NL; l++) inj_en[l] = 1'b0;
      step(IDLE_P + 10);
      for (int l = 0; l < NL; l++) begin
        checks++; if (sl(lat_min, l) !== 16'(dly[l] + 1)) begin errors++; $display("FAIL rnd%0d_min lane%0d got %0d want %0d", r, l, sl(lat_min, l), dly[l] + 1); end
        checks++; if (sl(lat_max, l) !== 16'(dly[l] + 1)) begin errors++; $display("FAIL rnd%0d_max lane%0d got %0d want %0d", r, l, sl(lat_max, l), dly[l] + 1); end
        checks++; if (sl(err_cnt, l) !== 16'(exp_err[l])) begin errors++; $display("FAIL rnd%0d_err lane%0d got %0d want %0d", r, l, sl(err_cnt, l), exp_err[l]); end
      end
      checks++; if (fail !== {NL{1'b1}}) begin errors++; $display("FAIL rnd%0d_fail got %b want all 1", r, fail); end
    end
  endtask

  task automatic test_ts_wrap();
    bit ok;
    for (int l = 0; l < NL; l++) dly[l] = 4;
    reset_pulse();
    ok = 1'b0;
    for (int c = 0; c < 70000 && !ok; c++) begin
      step(1);
      if (m_ts == 16'hFFF0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_reach got %h want FFF0", m_ts); end
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int c = 0; c < 100 && m_ts != 16'h0010; c++) step(1);
    for (int l = 0; l < NL; l++) begin
      checks++; if (sl(lat_min, l) !== 16'd5 || sl(lat_max, l) !== 16'd5) begin errors++; $display("FAIL wrap_lat lane%0d got %0d/%0d want 5/5", l, sl(lat_min, l), sl(lat_max, l)); end
      checks++; if (sl(err_cnt, l) !== 16'd0) begin errors++; $display("FAIL wrap_err lane%0d got %0d want 0", l, sl(err_cnt, l)); end
    end
  endtask

  initial begin
    test_reset();
    test_valid_low();
    test_loopback_pass();
    test_lane_error();
    test_realign();
    test_clear();
    test_random();
    test_ts_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gt_link_latency_monitor.md
GT_LINK_LATENCY_MONITOR -- requirements
Module: gt_link_latency_monitor

Interface
REQ-001 SHALL have parameter g_NUM_LANES, default 2, number of independent GT lanes checked (1..8).
REQ-002 SHALL have parameter g_IDLE, default 16'hBC95, IDLE word (comma K28.5 in upper byte).
REQ-003 SHALL have parameter g_IDLE_PERIOD, default 193, TX cycles between forced IDLE words (>=2).
REQ-004 SHALL have parameter g_BLIND_PERIOD, default 10, cycles ignored after rx_aligned_i rises.
REQ-005 SHALL have parameter g_NUM_SUCCESSFUL_DATA, default 1000, payload words required before pass.
REQ-006 SHALL have port usrclk_i, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port valid_i, input, 1, link up; low forces IDLE on TX and suppresses realign.
REQ-009 SHALL have port clear_stats_i, input, 1, one-cycle pulse clearing all statistics.
REQ-010 SHALL have ports tx_data_o, output, 16*g_NUM_LANES, and tx_k_o, output, 2*g_NUM_LANES; lane n at slice [16n+15:16n] / [2n+1:2n].
REQ-011 SHALL have ports rx_data_i, input, 16*g_NUM_LANES, and rx_k_i, input, 2*g_NUM_LANES, same slicing.
REQ-012 SHALL have ports rx_aligned_i, input, g_NUM_LANES, and rx_realign_o, output, g_NUM_LANES.
REQ-013 SHALL have port fail_o, output, g_NUM_LANES, per-lane fail flag.
REQ-014 SHALL have ports latency_min_o, latency_max_o, err_cnt_o, outputs, 16*g_NUM_LANES each.

Function
REQ-015 SHALL keep a 16-bit free-running timestamp ts, +1 per cycle, wrapping 16'hFFFF->0; no simulation-time constructs.
REQ-016 SHALL keep an IDLE counter 0..g_IDLE_PERIOD-1, +1 per cycle, wrapping to 0.
REQ-017 SHALL drive every lane, registered (1-cycle latency): IDLE word, k=2'b10 when valid_i=0 or IDLE counter=0; else current ts, k=2'b00.
REQ-018 SHALL register rx_realign_o[n] = valid_i & ~rx_aligned_i[n].
REQ-019 SHALL run per-lane FSM UNALIGNED, BLIND, WAIT_COMMA, LOCKED.
REQ-020 SHALL go to UNALIGNED from any state when rx_aligned_i[n]=0, with fail_o[n]=1 and success count cleared.
REQ-021 UNALIGNED->BLIND when rx_aligned_i[n]=1; BLIND lasts exactly g_BLIND_PERIOD+1 cycles, RX ignored, then WAIT_COMMA.
REQ-022 WAIT_COMMA: k=2'b10 with data=g_IDLE -> LOCKED; k=2'b00 ignored; any other k/data -> error.
REQ-023 LOCKED: k=2'b00 -> sample latency=(ts - rx_data) mod 2^16, update min/max, success count +1; k=2'b10 with g_IDLE -> stay; else error.
REQ-024 Error SHALL: err_cnt_o[n] +1 saturating at 16'hFFFF, fail_o[n]=1, success count cleared, state -> WAIT_COMMA.
REQ-025 Success count SHALL saturate at g_NUM_SUCCESSFUL_DATA+1; fail_o[n]=0 the cycle after it exceeds g_NUM_SUCCESSFUL_DATA.
REQ-026 Min/max SHALL update in the cycle after the sample; min uses strict <, max strict >.
REQ-027 clear_stats_i SHALL set all lanes min=16'hFFFF, max=0, err_cnt=0, success count=0, fail_o=1; FSM state unchanged; clear wins over a same-cycle sample or error.
REQ-028 Lanes SHALL be fully independent; an event on one lane never alters another lane's state or outputs.

Reset
REQ-029 rst_i=1 SHALL set: ts=0, IDLE counter=0, tx_data_o=all g_IDLE, tx_k_o=all 2'b10, rx_realign_o=0, fail_o=all 1, latency_min_o=all 16'hFFFF, latency_max_o=0, err_cnt_o=0, FSMs UNALIGNED.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge, overriding clear_stats_i and all RX events.

Verification
REQ-031 2 lanes, loopback with 5-cycle delay, valid_i=1, aligned -> fail_o=2'b00 after ~1000 payload words, min=max=6 on both lanes.
REQ-032 valid_i=0 -> tx_k_o all 2'b10, tx_data_o all 16'hBC95; rx_realign_o=0 regardless of rx_aligned_i.
REQ-033 Lane 1 injects k=2'b01 while LOCKED -> err_cnt lane1=1, fail_o[1]=1, lane 0 unaffected.
REQ-034 Drop rx_aligned_i[0] for 1 cycle after pass -> fail_o[0]=1, 11 blind cycles, relock, pass again after 1001 words.
REQ-035 Delay straddling ts wrap (tx ts=16'hFFFE, rx at ts=16'h0003) -> latency 5, no error.
REQ-036 clear_stats_i same cycle as an error -> err_cnt=0, min=16'hFFFF, max=0, fail_o=1.
